// File: rtl/id_hazard_unit_pkg.sv
// Shared types for the ID-stage hazard unit: forward-select codes, FSM states,
// shadow-slot layout and the never-forwarded PC register index.
// Pure declarations; no logic and no timing of its own.
package id_hazard_unit_pkg;

  // Register index width (R0..R15)
  localparam int REG_W = 4;

  // Register index that is tracked in the shadow but never forwarded
  localparam logic [REG_W-1:0] PC_REG = 4'd15;

  // Operand forward-select encodings seen by the ID forwarding muxes
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  // Hazard FSM states
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_HOLD = 2'd2
  } hz_state_e;

  // Destination tag portion of a slot: what the forwarding match looks at
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             we;
  } tag_t;

  // One shadow slot: destination tag plus the load flag used for load-use
  typedef struct packed {
    tag_t tag;
    logic is_load;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  // A slot can supply a source when it holds a live write to that register
  // and the register is not the PC.
  function automatic logic tag_match(input tag_t t, input logic [REG_W-1:0] src);
    return t.valid && t.we && (t.rd == src) && (src != PC_REG);
  endfunction

endpackage

// File: rtl/id_hazard_unit_fwd_select.sv
// Priority forward-select for one ID source operand (EX > MEM > WB > reg).
// Purely combinational, zero latency.
// No backpressure; flags a load-use hit so the top can stall, forcing 00.
module hazard_fwd_select
  import id_hazard_unit_pkg::*;
(
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] src_i,
  input  logic             used_i,
  input  tag_t             ex_tag_i,
  input  logic             ex_is_load_i,
  input  tag_t             mem_tag_i,
  input  tag_t             wb_tag_i,
  output fwd_sel_e         sel_o,
  output logic             load_use_o
);

  logic active;

  assign active = id_valid_i && used_i;

  // Youngest matching producer wins; a load still in EX cannot forward yet.
  always_comb begin
    sel_o      = FWD_REG;
    load_use_o = 1'b0;
    if (active) begin
      if (tag_match(ex_tag_i, src_i)) begin
        if (ex_is_load_i) begin
          load_use_o = 1'b1;
        end else begin
          sel_o = FWD_EX;
        end
      end else if (tag_match(mem_tag_i, src_i)) begin
        sel_o = FWD_MEM;
      end else if (tag_match(wb_tag_i, src_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/id_hazard_unit.sv
// ID-stage hazard unit: EX/MEM/WB destination shadow, operand forward selects,
// load-use stall/bubble and memory-wait freeze. Optional stall counter under
// HAZARD_STATS_EN. Controls are combinational; slots/state update on clk.
module id_hazard_unit
  import id_hazard_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_rn_used,
  input  logic             id_rm_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_rd_we,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             mem_wait,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             freeze
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  slot_t     ex_q, mem_q, wb_q;
  slot_t     ex_d, mem_d, wb_d;
  hz_state_e state_q, ret_q;
  fwd_sel_e  sel_a, sel_b;
  logic      lu_a, lu_b;
  logic      load_use;

  hazard_fwd_select u_fwd_a (
    .id_valid_i   (id_valid),
    .src_i        (id_rn),
    .used_i       (id_rn_used),
    .ex_tag_i     (ex_q.tag),
    .ex_is_load_i (ex_q.is_load),
    .mem_tag_i    (mem_q.tag),
    .wb_tag_i     (wb_q.tag),
    .sel_o        (sel_a),
    .load_use_o   (lu_a)
  );

  hazard_fwd_select u_fwd_b (
    .id_valid_i   (id_valid),
    .src_i        (id_rm),
    .used_i       (id_rm_used),
    .ex_tag_i     (ex_q.tag),
    .ex_is_load_i (ex_q.is_load),
    .mem_tag_i    (mem_q.tag),
    .wb_tag_i     (wb_q.tag),
    .sel_o        (sel_b),
    .load_use_o   (lu_b)
  );

  assign load_use = lu_a || lu_b;

  // Outputs are forced quiet while reset is asserted so the pipeline sees
  // no stall or forwarding during the reset cycle itself.
  assign fwd_sel_a = reset_n ? sel_a : FWD_REG;
  assign fwd_sel_b = reset_n ? sel_b : FWD_REG;
  assign freeze    = reset_n && mem_wait;
  assign stall_id  = reset_n && (mem_wait || load_use);
  assign bubble_ex = reset_n && !mem_wait && load_use;

  // Slot advance: frozen pipeline holds everything; otherwise shift down and
  // admit the ID instruction unless it is stalled, squashed or not valid.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!mem_wait) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (id_valid && !load_use && !flush) begin
        ex_d.tag.valid = 1'b1;
        ex_d.tag.rd    = id_rd;
        ex_d.tag.we    = id_rd_we;
        ex_d.is_load   = id_is_load;
      end else begin
        ex_d = SLOT_EMPTY;
      end
    end
  end

  // Shadow slot registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_q  <= SLOT_EMPTY;
      mem_q <= SLOT_EMPTY;
      wb_q  <= SLOT_EMPTY;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // Hazard FSM: memory wait overrides everything and remembers where to
  // resume; a flush in the stall cycle simply lands back in RUN.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
    end else if (mem_wait) begin
      state_q <= ST_MEM_HOLD;
      if (state_q != ST_MEM_HOLD) begin
        ret_q <= state_q;
      end
    end else begin
      case (state_q)
        ST_RUN:      state_q <= (load_use && !flush) ? ST_LU_STALL : ST_RUN;
        ST_LU_STALL: state_q <= ST_RUN;
        ST_MEM_HOLD: state_q <= ret_q;
        default:     state_q <= ST_RUN;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q;

  assign stall_cycles = stall_cnt_q;

  // Saturating count of every cycle the ID stage was held
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_q <= 16'h0000;
    end else if (stall_id && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'h0001;
    end
  end
`endif

endmodule
